dual_pueo_thresh_loader: RTL and testbench

//  Drives the dual-threshold cascade of a chain of NBEAMS dual-beam trigger modules from the

---
 rtl/dual_pueo_thresh_loader.sv | 157 +++++++++++++++
 tb/tb_dual_pueo_thresh_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_pueo_thresh_loader.sv
// dual_pueo_thresh_loader
// Stages per-beam A/B thresholds written by software, then shifts them into the
// dual-beam trigger cascade (last beam first) and commits them with a single
// update strobe so every beam switches thresholds on the same clock.
module dual_pueo_thresh_loader #(
    parameter int NBEAMS = 48,
    parameter int TBITS  = 18,
    localparam int AW    = $clog2(NBEAMS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AW-1:0]        thr_addr_i,
    input  logic [TBITS-1:0]     thr_dat_i,
    input  logic                 thr_sel_i,
    input  logic                 thr_wr_i,
    input  logic [1:0]           load_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic                 err_clr_i,
    output logic [2*TBITS-1:0]   thresh_o,
    output logic [1:0]           thresh_wr_o,
    output logic [1:0]           thresh_update_o
);

    localparam logic [AW:0]   NBEAMS_L = NBEAMS[AW:0];
    localparam logic [AW-1:0] LAST_IDX = AW'(NBEAMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             mask_q, mask_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [2*TBITS-1:0]     thresh_q, thresh_d;
    logic [1:0]             wr_q, wr_d;
    logic [1:0]             upd_q, upd_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    // Staging RAM: one A and one B threshold per beam, never reset.
    logic [TBITS-1:0]       ram_a_q [NBEAMS];
    logic [TBITS-1:0]       ram_b_q [NBEAMS];

    logic                   stage_we;
    logic                   rd_en;
    logic [AW-1:0]          rd_idx;
    logic                   err_set;

    // Writes land only while idle and only for existing beams; anything else is dropped.
    assign stage_we = thr_wr_i && (state_q == ST_IDLE) && ({1'b0, thr_addr_i} < NBEAMS_L);

    // Staging RAM write port.
    always_ff @(posedge clk_i) begin
        if (stage_we) begin
            if (thr_sel_i) begin
                ram_b_q[thr_addr_i] <= thr_dat_i;
            end else begin
                ram_a_q[thr_addr_i] <= thr_dat_i;
            end
        end
    end

    // Next-state and output logic for the load sequencer.
    // The RAM read result is captured straight into the thresh register, so a read
    // issued in one cycle appears on thresh_o together with its wr strobe the next.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ptr_d    = ptr_q;
        thresh_d = thresh_q;
        wr_d     = 2'b00;
        upd_d    = 2'b00;
        done_d   = 1'b0;
        rd_en    = 1'b0;
        rd_idx   = ptr_q;

        // Any write or load attempt while a sequence runs is rejected; set beats clear.
        err_set = (state_q != ST_IDLE) && (thr_wr_i || (load_i != 2'b00));
        err_d   = err_set || (err_q && !err_clr_i);

        case (state_q)
            ST_IDLE: begin
                if (load_i != 2'b00) begin
                    mask_d  = load_i;
                    ptr_d   = LAST_IDX;
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                // First read: the last beam's entry goes in first so it ends up farthest.
                rd_en   = 1'b1;
                rd_idx  = ptr_q;
                wr_d    = mask_q;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // ptr_q is the entry currently on thresh_o; fetch the next lower one.
                if (ptr_q != '0) begin
                    rd_en  = 1'b1;
                    rd_idx = ptr_q - 1'b1;
                    ptr_d  = ptr_q - 1'b1;
                    wr_d   = mask_q;
                end else begin
                    upd_d   = mask_q;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rd_en) begin
            thresh_d = {ram_b_q[rd_idx], ram_a_q[rd_idx]};
        end
    end

    // Sequencer and output registers; reset drops every strobe at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            mask_q   <= 2'b00;
            ptr_q    <= '0;
            thresh_q <= '0;
            wr_q     <= 2'b00;
            upd_q    <= 2'b00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ptr_q    <= ptr_d;
            thresh_q <= thresh_d;
            wr_q     <= wr_d;
            upd_q    <= upd_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign thresh_o        = thresh_q;
    assign thresh_wr_o     = wr_q;
    assign thresh_update_o = upd_q;

endmodule

// File: tb/tb_dual_pueo_thresh_loader.sv
// Directed bench for dual_pueo_thresh_loader with NBEAMS=4.
module tb_dual_pueo_thresh_loader;

    localparam int NB = 4;
    localparam int TB = 18;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [1:0]      thr_addr_i;
    logic [TB-1:0]   thr_dat_i;
    logic            thr_sel_i;
    logic            thr_wr_i;
    logic [1:0]      load_i;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic            err_clr_i;
    logic [2*TB-1:0] thresh_o;
    logic [1:0]      thresh_wr_o;
    logic [1:0]      thresh_update_o;

    int errors = 0;
    int checks = 0;

    // bench-side models: staging contents, beam shift registers, committed thresholds
    logic [TB-1:0] stage_a [NB];
    logic [TB-1:0] stage_b [NB];
    logic [TB-1:0] casc_a  [NB];
    logic [TB-1:0] casc_b  [NB];
    logic [TB-1:0] comm_a  [NB];
    logic [TB-1:0] comm_b  [NB];

    dual_pueo_thresh_loader #(.NBEAMS(NB), .TBITS(TB)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .thr_addr_i      (thr_addr_i),
        .thr_dat_i       (thr_dat_i),
        .thr_sel_i       (thr_sel_i),
        .thr_wr_i        (thr_wr_i),
        .load_i          (load_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .err_clr_i       (err_clr_i),
        .thresh_o        (thresh_o),
        .thresh_wr_o     (thresh_wr_o),
        .thresh_update_o (thresh_update_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        sel;
        logic [1:0]  addr;
        logic [17:0] dat;
        logic [1:0]  load;
        logic        clr;
        logic        busy;
        logic        done;
        logic        err;
        logic [1:0]  wro;
        logic [1:0]  upd;
        logic [35:0] th;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] th(input int k);
        logic [17:0] a;
        logic [17:0] b;
        a = 18'(32'h100 + k);
        b = 18'(32'h200 + k);
        return {b, a};
    endfunction

    task automatic add(input logic wr, input logic sel, input logic [1:0] addr,
                       input logic [17:0] dat, input logic [1:0] load, input logic clr,
                       input logic busy, input logic done, input logic err,
                       input logic [1:0] wro, input logic [1:0] upd, input logic [35:0] t);
        vec_t v;
        v.wr = wr; v.sel = sel; v.addr = addr; v.dat = dat; v.load = load; v.clr = clr;
        v.busy = busy; v.done = done; v.err = err; v.wro = wro; v.upd = upd; v.th = t;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        thr_wr_i   = 1'b0;
        thr_sel_i  = 1'b0;
        thr_addr_i = 2'd0;
        thr_dat_i  = '0;
        load_i     = 2'b00;
        err_clr_i  = 1'b0;
    endtask

    task automatic wr_entry(input int idx, input logic sel, input logic [17:0] dat);
        thr_wr_i   = 1'b1;
        thr_sel_i  = sel;
        thr_addr_i = 2'(idx);
        thr_dat_i  = dat;
        if (sel) stage_b[idx] = dat;
        else     stage_a[idx] = dat;
        tick();
        idle_inputs();
    endtask

    // Runs one load from cycle 0, optionally with a same-cycle staging write,
    // tracking the beam cascade and checking the strobe timing and commits.
    task automatic run_load(input logic [1:0] mask, input logic do_wr, input logic wsel,
                            input int widx, input logic [17:0] wdat, input string tag);
        int cyc;
        int nwr  [2];
        int nupd [2];
        int first_wr;
        int last_wr;
        int done_cyc;
        logic [35:0] first_val;
        nwr[0] = 0; nwr[1] = 0; nupd[0] = 0; nupd[1] = 0;
        first_wr = -1; last_wr = -1; done_cyc = -1; first_val = '0;
        if (do_wr) begin
            thr_wr_i   = 1'b1;
            thr_sel_i  = wsel;
            thr_addr_i = 2'(widx);
            thr_dat_i  = wdat;
            if (wsel) stage_b[widx] = wdat;
            else      stage_a[widx] = wdat;
        end
        load_i = mask;
        tick();
        idle_inputs();
        cyc = 1;
        while (cyc <= 20) begin
            for (int c = 0; c < 2; c++) begin
                if (thresh_wr_o[c]) nwr[c]++;
                if (thresh_update_o[c]) nupd[c]++;
            end
            if (thresh_wr_o != 2'b00) begin
                if (first_wr < 0) begin
                    first_wr  = cyc;
                    first_val = thresh_o;
                end
                last_wr = cyc;
            end
            if (thresh_wr_o[0]) begin
                for (int k = NB - 1; k > 0; k--) casc_a[k] = casc_a[k-1];
                casc_a[0] = thresh_o[17:0];
            end
            if (thresh_wr_o[1]) begin
                for (int k = NB - 1; k > 0; k--) casc_b[k] = casc_b[k-1];
                casc_b[0] = thresh_o[35:18];
            end
            if (thresh_update_o[0]) for (int k = 0; k < NB; k++) comm_a[k] = casc_a[k];
            if (thresh_update_o[1]) for (int k = 0; k < NB; k++) comm_b[k] = casc_b[k];
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(NB + 3));
        check({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
        check({tag, "_wr_count_a"}, 64'(nwr[0]), mask[0] ? 64'(NB) : 64'd0);
        check({tag, "_wr_count_b"}, 64'(nwr[1]), mask[1] ? 64'(NB) : 64'd0);
        check({tag, "_upd_count"}, {32'(nupd[1]), 32'(nupd[0])},
              {32'(mask[1] ? 1 : 0), 32'(mask[0] ? 1 : 0)});
        check({tag, "_wr_window"}, {32'(first_wr), 32'(last_wr)}, {32'd2, 32'(NB + 1)});
        check({tag, "_first_value"}, 64'(first_val), 64'({stage_b[NB-1], stage_a[NB-1]}));
        for (int k = 0; k < NB; k++) begin
            if (mask[0]) check($sformatf("%s_beam%0d_a", tag, k), 64'(comm_a[k]), 64'(stage_a[k]));
            if (mask[1]) check($sformatf("%s_beam%0d_b", tag, k), 64'(comm_b[k]), 64'(stage_b[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();
        rst_ni = 1'b0;
        for (int k = 0; k < NB; k++) begin
            casc_a[k] = '0; casc_b[k] = '0; comm_a[k] = '0; comm_b[k] = '0;
        end
        tick();
        tick();
        check("reset_outputs", {busy_o, done_o, err_o, thresh_wr_o, thresh_update_o, thresh_o},
              '0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < NB; i++) begin
            wr_entry(i, 1'b0, 18'(32'h100 + i));
            wr_entry(i, 1'b1, 18'(32'h200 + i));
        end

        // load both chains
        add(0,0,0,0,2'b11,0, 1,0,0,2'b00,2'b00, 36'h0);
        add(0,0,0,0,2'b00,0, 1,0,0,2'b11,2'b00, th(3));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b11,2'b00, th(2));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b11,2'b00, th(1));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b11,2'b00, th(0));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b00,2'b11, th(0));
        add(0,0,0,0,2'b00,0, 0,1,0,2'b00,2'b00, th(0));
        add(0,0,0,0,2'b00,0, 0,0,0,2'b00,2'b00, th(0));
        // A chain only
        add(0,0,0,0,2'b01,0, 1,0,0,2'b00,2'b00, th(0));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b01,2'b00, th(3));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b01,2'b00, th(2));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b01,2'b00, th(1));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b01,2'b00, th(0));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b00,2'b01, th(0));
        add(0,0,0,0,2'b00,0, 0,1,0,2'b00,2'b00, th(0));
        add(0,0,0,0,2'b00,0, 0,0,0,2'b00,2'b00, th(0));
        // rejected load at cycle 3 and rejected write at cycle 4, then clear
        add(0,0,0,0,2'b11,0, 1,0,0,2'b00,2'b00, th(0));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b11,2'b00, th(3));
        add(0,0,0,0,2'b00,0, 1,0,0,2'b11,2'b00, th(2));
        add(0,0,0,0,2'b11,0, 1,0,1,2'b11,2'b00, th(1));
        add(1,0,0,18'h0AAA,2'b00,0, 1,0,1,2'b11,2'b00, th(0));
        add(0,0,0,0,2'b00,0, 1,0,1,2'b00,2'b11, th(0));
        add(0,0,0,0,2'b00,0, 0,1,1,2'b00,2'b00, th(0));
        add(0,0,0,0,2'b00,1, 0,0,0,2'b00,2'b00, th(0));

        foreach (vecs[i]) begin
            thr_wr_i   = vecs[i].wr;
            thr_sel_i  = vecs[i].sel;
            thr_addr_i = vecs[i].addr;
            thr_dat_i  = vecs[i].dat;
            load_i     = vecs[i].load;
            err_clr_i  = vecs[i].clr;
            tick();
            check($sformatf("vec%0d", i),
                  64'({busy_o, done_o, err_o, thresh_wr_o, thresh_update_o, thresh_o}),
                  64'({vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].wro, vecs[i].upd,
                       vecs[i].th}));
        end
        idle_inputs();
        tick();

        // rejected write must not have touched entry 0; then same-cycle write+load
        run_load(2'b11, 1'b0, 1'b0, 0, '0, "full");
        run_load(2'b11, 1'b1, 1'b0, 3, 18'h3FFFF, "wr_with_load");

        // error set and clear in the same cycle: set wins
        load_i = 2'b11;
        tick();
        load_i    = 2'b11;
        err_clr_i = 1'b1;
        tick();
        check("err_set_beats_clr", 64'(err_o), 64'd1);
        load_i    = 2'b00;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("err_clr", 64'(err_o), 64'd0);
        n = 0;
        while (busy_o && n < 20) begin
            tick();
            n++;
        end
        check("busy_release", 64'(busy_o), 64'd0);

        // asynchronous reset in the middle of a shift
        load_i = 2'b11;
        tick();
        load_i = 2'b00;
        tick();
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({busy_o, done_o, err_o, thresh_wr_o, thresh_update_o, thresh_o}), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (thresh_update_o != 2'b00 || busy_o || thresh_wr_o != 2'b00) n++;
        end
        check("no_strobes_after_reset", 64'(n), 64'd0);

        run_load(2'b11, 1'b0, 1'b0, 0, '0, "after_reset");
        run_load(2'b01, 1'b1, 1'b1, 1, 18'h2BEEF, "b2b_a_only");
        run_load(2'b10, 1'b1, 1'b1, 2, 18'h15A5A, "b2b_b_only");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
